// File: rtl/muldiv_pkg.sv
// Shared definitions for the iterative RV32M multiply/divide unit:
// funct3 operation codes, FSM state encoding and the default width.
package muldiv_pkg;
  localparam int XLEN = 32;

  localparam logic [2:0] OP_MUL    = 3'b000;
  localparam logic [2:0] OP_MULH   = 3'b001;
  localparam logic [2:0] OP_MULHSU = 3'b010;
  localparam logic [2:0] OP_MULHU  = 3'b011;
  localparam logic [2:0] OP_DIV    = 3'b100;
  localparam logic [2:0] OP_DIVU   = 3'b101;
  localparam logic [2:0] OP_REM    = 3'b110;
  localparam logic [2:0] OP_REMU   = 3'b111;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_PREP  = 3'd1,
    S_CALC  = 3'd2,
    S_FIXUP = 3'd3,
    S_DONE  = 3'd4
  } state_t;
endpackage

// File: rtl/muldiv_iter.sv
// One combinational iteration: shift-add multiply step or restoring divide step.
// hi/lo hold the product halves (mul) or the partial remainder/quotient (div).
module muldiv_iter
  import muldiv_pkg::*;
#(
  parameter int W = XLEN
) (
  input  logic         is_div,
  input  logic [W-1:0] hi,
  input  logic [W-1:0] lo,
  input  logic [W-1:0] operand,
  output logic [W-1:0] hi_next,
  output logic [W-1:0] lo_next
);
  logic [W:0]   sum;
  logic [W:0]   rem33;
  logic [W-1:0] diff;

  // 33-bit add keeps the carry that is shifted back into hi.
  assign sum   = {1'b0, hi} + (lo[0] ? {1'b0, operand} : '0);
  assign rem33 = {hi, lo[W-1]};
  // Only used when rem33 >= operand, so the difference fits in W bits.
  assign diff  = rem33[W-1:0] - operand;

  always_comb begin
    hi_next = sum[W:1];
    lo_next = {sum[0], lo[W-1:1]};
    if (is_div) begin
      if (rem33 >= {1'b0, operand}) begin
        hi_next = diff;
        lo_next = {lo[W-2:0], 1'b1};
      end else begin
        hi_next = rem33[W-1:0];
        lo_next = {lo[W-2:0], 1'b0};
      end
    end
  end
endmodule

// File: rtl/muldiv_seq.sv
// Iterative RV32M MUL/DIV unit: magnitudes in PREP, 32 iterations in CALC,
// sign fix-up and result select in FIXUP, one-cycle done pulse in DONE.
module muldiv_seq
  import muldiv_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int CNT_W = 5
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic            kill,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);
  state_t            state;
  logic [2:0]        op_q;
  logic [XLEN-1:0]   a_q, b_q;
  logic [XLEN-1:0]   hi, lo, mcand;
  logic [XLEN-1:0]   hi_next, lo_next;
  logic [CNT_W-1:0]  cnt;
  logic              neg_q;

  logic              is_div, a_signed, b_signed, sa, sb, neg_flag, ovf;
  logic [XLEN-1:0]   mag_a, mag_b, rem_fix, fix_result;
  logic [2*XLEN-1:0] prod, prod_fix;

  assign is_div   = op_q[2];
  assign a_signed = (op_q == OP_MULH) || (op_q == OP_MULHSU) ||
                    (op_q == OP_DIV)  || (op_q == OP_REM);
  assign b_signed = (op_q == OP_MULH) || (op_q == OP_DIV) || (op_q == OP_REM);
  assign sa       = a_signed & a_q[XLEN-1];
  assign sb       = b_signed & b_q[XLEN-1];
  assign mag_a    = sa ? ('0 - a_q) : a_q;
  assign mag_b    = sb ? ('0 - b_q) : b_q;
  // Remainder takes the dividend's sign; product and quotient take sa^sb.
  assign neg_flag = (is_div && op_q[1]) ? sa : (sa ^ sb);
  assign ovf      = ((op_q == OP_DIV) || (op_q == OP_REM)) &&
                    (a_q == {1'b1, {(XLEN-1){1'b0}}}) && (b_q == '1);

  assign prod     = {hi, lo};
  assign prod_fix = neg_q ? ('0 - prod) : prod;
  assign rem_fix  = neg_q ? ('0 - hi) : hi;

  always_comb begin
    fix_result = prod_fix[XLEN-1:0];
    case (op_q)
      OP_MULH, OP_MULHSU, OP_MULHU: fix_result = prod_fix[2*XLEN-1:XLEN];
      OP_REM, OP_REMU:              fix_result = rem_fix;
      default:                      fix_result = prod_fix[XLEN-1:0];
    endcase
  end

  muldiv_iter #(.W(XLEN)) u_iter (
    .is_div  (is_div),
    .hi      (hi),
    .lo      (lo),
    .operand (mcand),
    .hi_next (hi_next),
    .lo_next (lo_next)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= S_IDLE;
      busy   <= 1'b0;
      done   <= 1'b0;
      result <= '0;
      op_q   <= '0;
      a_q    <= '0;
      b_q    <= '0;
      hi     <= '0;
      lo     <= '0;
      mcand  <= '0;
      cnt    <= '0;
      neg_q  <= 1'b0;
    end else if (kill) begin
      state <= S_IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            op_q  <= op;
            a_q   <= a;
            b_q   <= b;
            state <= S_PREP;
            busy  <= 1'b1;
          end else begin
            state <= S_IDLE;
            busy  <= 1'b0;
          end
        end
        S_PREP: begin
          if (is_div && (b_q == '0)) begin
            result <= op_q[1] ? a_q : '1;
            state  <= S_DONE;
            busy   <= 1'b0;
            done   <= 1'b1;
          end else if (ovf) begin
            result <= op_q[1] ? '0 : a_q;
            state  <= S_DONE;
            busy   <= 1'b0;
            done   <= 1'b1;
          end else begin
            hi    <= '0;
            lo    <= is_div ? mag_a : mag_b;
            mcand <= is_div ? mag_b : mag_a;
            neg_q <= neg_flag;
            cnt   <= CNT_W'(XLEN - 1);
            state <= S_CALC;
          end
        end
        S_CALC: begin
          hi  <= hi_next;
          lo  <= lo_next;
          cnt <= cnt - CNT_W'(1);
          if (cnt == '0) state <= S_FIXUP;
        end
        S_FIXUP: begin
          result <= fix_result;
          state  <= S_DONE;
          busy   <= 1'b0;
          done   <= 1'b1;
        end
        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: doc/muldiv_seq.md
Name: muldiv_seq

Overview:
- Iterative RV32M multiply/divide unit; sits beside the combinational ALU in the EX stage.
- Executes MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU over multiple cycles.
- Pipeline control asserts start, stalls while busy and consumes result on done.
- Shift-add multiply and restoring divide on magnitudes, with a sign fix-up at the end.

Parameters:
- XLEN, 32, operand/result width; only 32 is supported and verified.
- CNT_W, 5, iteration counter width (log2 XLEN).

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  reset, synchronous, active-low
- start  input  1  request; sampled only when busy=0
- op  input  3  funct3 encoding: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
- a  input  32  rs1 operand (dividend / multiplicand)
- b  input  32  rs2 operand (divisor / multiplier)
- kill  input  1  abort current operation (pipeline flush)
- busy  output  1  high in PREP, CALC, FIXUP
- done  output  1  one-cycle pulse; result is valid
- result  output  32  final value; held until the next accepted start

Behaviour:
- Reset: rst_n low at an edge forces state IDLE, busy=0, done=0, result=0, counter=0, all internal registers cleared. This applies mid-operation too.
- States:
  - IDLE: start & !kill -> PREP; latch op, a, b.
  - PREP, one cycle:
    - Compute magnitudes: a is signed for MULH/MULHSU/DIV/REM; b is signed for MULH/DIV/REM. MUL is treated as unsigned (the low word is identical).
    - Record the negate flag: product sign = sa^sb; quotient sign = sa^sb; remainder sign = sa.
    - Special cases for div ops go directly -> DONE:
      - b==0: quotient = 0xFFFFFFFF, remainder = a.
      - Signed overflow (a==0x80000000, b==0xFFFFFFFF, DIV/REM): quotient = 0x80000000, remainder = 0.
    - Otherwise -> CALC with counter=31.
  - CALC, 32 cycles, one iteration per cycle, counter decrements; counter==0 -> FIXUP.
    - Multiply: 64-bit {hi,lo}. If lo[0], hi_next = hi + mcand using a 33-bit add. Then shift {carry,hi,lo} right by 1.
    - Divide: rem33 = {rem,q_msb}. If rem33 >= divisor, subtract and shift in quotient bit 1, else shift in 0.
  - FIXUP, one cycle: two's-complement negate the 64-bit product or the quotient/remainder if the flag is set. Select the low word (MUL), high word (MULH*), quotient or remainder. -> DONE.
  - DONE: done=1 for this cycle only; result register updated on entry. busy=0. start here is accepted (-> PREP), giving back-to-back operation.
- Latency, start sampled at edge k:
  - Normal op: done high in the cycle following edge k+34.
  - Special-case div: done high in the cycle following edge k+1.
  - Throughput: one op per 35 cycles.
- start while busy=1: ignored, no queuing.
- kill: in any state, next state is IDLE. done is not asserted and result is unchanged. kill with start in the same cycle: kill wins, start is dropped.
- rst_n has priority over kill.
- Operands are latched at accept; changes on a/b/op during busy have no effect.
- Arithmetic is modulo 2^32 on outputs. Internal adders are 33-bit so no carry/borrow is lost. Negating 0x80000000 yields 0x80000000 (correct as an unsigned magnitude).

Decomposition:
- Shared package muldiv_pkg holds:
  - op localparams (OP_MUL..OP_REMU, matching funct3);
  - state encoding (S_IDLE, S_PREP, S_CALC, S_FIXUP, S_DONE; 3 bits);
  - XLEN default.
- One sub-module is natural: muldiv_iter, the combinational single-iteration step (mul add/shift or div compare/subtract/shift). It is selected by an is_div input and instantiated once; the FSM and registers stay in muldiv_seq.

Test Plan:
- MUL a=7, b=0xFFFFFFFD (-3) -> result 0xFFFFFFEB; done one cycle wide, after edge k+34; busy high for exactly 34 cycles.
- a=b=0xFFFFFFFF -> MULHU 0xFFFFFFFE; MULH 0x00000000; MULHSU 0xFFFFFFFF; MUL 0x00000001.
- Signed and unsigned division:
  - DIV 0xFFFFFFF9 (-7) / 2 -> 0xFFFFFFFD; REM -> 0xFFFFFFFF.
  - DIVU 100/7 -> 14; REMU -> 2.
  - Issue back-to-back, with start asserted in the DONE cycle.
- Special-case division:
  - DIVU 5/0 -> 0xFFFFFFFF; REM 5/0 -> 5; DIV 0x80000000/0xFFFFFFFF -> 0x80000000; REM -> 0.
  - Each has done after edge k+1.
- kill asserted on the 10th CALC cycle -> busy low next cycle, no done, result keeps its previous value. start+kill together in IDLE -> stays IDLE.
- Reset mid-CALC with rst_n=0 for one edge -> busy=0, done=0, result=0. start pulsed while busy -> ignored (no second done).
